fsa_pe_operand_sequencer: RTL and testbench

//  Upstream feeder for one FSA redundancy PE. Buffers operand beats
//  (activation, weight, partial-sum-in) from a valid/ready source in a small FIFO.

---
 rtl/fsa_pe_operand_sequencer.sv | 164 ++++++++++++++++
 tb/tb_fsa_pe_operand_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsa_pe_operand_sequencer.sv
// Operand sequencer for one FSA redundancy PE: queues (act, weight, psum) beats and
// issues them with the cs select that walks the PE through accumulate/hold/readout.
module fsa_pe_operand_sequencer #(
    parameter int DATA_W     = 16,
    parameter int N_ACC      = 4,
    parameter int HOLD_CYC   = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_act,
    input  logic [DATA_W-1:0] in_weight,
    input  logic [DATA_W-1:0] in_psum,
    output logic [1:0]        cs,
    output logic [DATA_W-1:0] act_out,
    output logic [DATA_W-1:0] weight_out,
    output logic [DATA_W-1:0] psum_out,
    output logic              weight_en,
    output logic              busy,
    output logic              done
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int BEAT_W = $clog2(N_ACC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_ACC - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYC - 1);

    localparam logic [1:0] CS_FIRST = 2'b00;
    localparam logic [1:0] CS_ACCUM = 2'b01;
    localparam logic [1:0] CS_HOLD  = 2'b10;
    localparam logic [1:0] CS_IDLE  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRST,
        S_ACCUM,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_reg;
    logic [BEAT_W-1:0]   beat_cnt_reg;
    logic [HOLD_W-1:0]   hold_cnt_reg;

    logic [3*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;
    logic                ready_en_reg;

    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [DATA_W-1:0]   head_act;
    logic [DATA_W-1:0]   head_weight;
    logic [DATA_W-1:0]   head_psum;

    // ready_en_reg keeps in_ready low while reset is held and for the release edge
    assign full     = (count_reg == DEPTH_C);
    assign empty    = (count_reg == '0);
    assign in_ready = ready_en_reg & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = ~empty & ((state_reg == S_FIRST) | (state_reg == S_ACCUM));
    assign {head_act, head_weight, head_psum} = mem[rd_ptr_reg];
    assign busy     = (state_reg != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_act, in_weight, in_psum};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ready_en_reg <= 1'b0;
        end else begin
            ready_en_reg <= 1'b1;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs are loaded on the same edge the beat is popped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= S_IDLE;
            beat_cnt_reg <= '0;
            hold_cnt_reg <= '0;
            cs           <= CS_IDLE;
            act_out      <= '0;
            weight_out   <= '0;
            psum_out     <= '0;
            weight_en    <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    cs        <= CS_IDLE;
                    {act_out, weight_out, psum_out} <= '0;
                    weight_en <= 1'b0;
                    if (!empty) state_reg <= S_FIRST;
                end
                S_FIRST: begin
                    cs           <= CS_FIRST;
                    {act_out, weight_out, psum_out} <= {head_act, head_weight, head_psum};
                    weight_en    <= 1'b1;
                    beat_cnt_reg <= BEAT_W'(1);
                    hold_cnt_reg <= '0;
                    state_reg    <= (N_ACC == 1) ? S_HOLD : S_ACCUM;
                end
                S_ACCUM: begin
                    if (!empty) begin
                        cs           <= CS_ACCUM;
                        {act_out, weight_out, psum_out} <= {head_act, head_weight, head_psum};
                        weight_en    <= 1'b1;
                        beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
                        if (beat_cnt_reg == LAST_BEAT) state_reg <= S_HOLD;
                    end else begin
                        // starved: park the PE in hold so it never sums stale data
                        cs        <= CS_HOLD;
                        {act_out, weight_out, psum_out} <= '0;
                        weight_en <= 1'b0;
                    end
                end
                S_HOLD: begin
                    cs           <= CS_HOLD;
                    {act_out, weight_out, psum_out} <= '0;
                    weight_en    <= 1'b0;
                    hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
                    if (hold_cnt_reg == LAST_HOLD) state_reg <= S_DONE;
                end
                S_DONE: begin
                    cs           <= CS_IDLE;
                    {act_out, weight_out, psum_out} <= '0;
                    weight_en    <= 1'b0;
                    done         <= 1'b1;
                    beat_cnt_reg <= '0;
                    hold_cnt_reg <= '0;
                    state_reg    <= empty ? S_IDLE : S_FIRST;
                end
                default: begin
                    state_reg <= S_IDLE;
                    cs        <= CS_IDLE;
                    {act_out, weight_out, psum_out} <= '0;
                    weight_en <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fsa_pe_operand_sequencer.sv
// Bench for fsa_pe_operand_sequencer: directed tables, hand sequences and random
// traffic checked against a queue-based tile model.
module tb_fsa_pe_operand_sequencer;
    localparam int DW = 16;
    localparam int NA = 4;
    localparam int HC = 4;
    localparam int FD = 4;

    typedef struct packed {
        logic [DW-1:0] act;
        logic [DW-1:0] weight;
        logic [DW-1:0] psum;
    } beat_t;

    typedef struct {
        bit            v;
        logic [DW-1:0] a;
        logic [DW-1:0] w;
        logic [DW-1:0] p;
        logic [1:0]    cs;
        bit            we;
        logic [DW-1:0] ea;
        logic [DW-1:0] ew;
        logic [DW-1:0] ep;
        bit            done;
        bit            busy;
        bit            ready;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, weight_en, busy, done;
    logic [DW-1:0] in_act, in_weight, in_psum, act_out, weight_out, psum_out;
    logic [1:0]    cs;

    logic          b_valid, b_ready, b_we, b_busy, b_done;
    logic [DW-1:0] b_act, b_weight, b_psum, b_act_out, b_weight_out, b_psum_out;
    logic [1:0]    b_cs;

    fsa_pe_operand_sequencer #(.DATA_W(DW), .N_ACC(NA), .HOLD_CYC(HC), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_act(in_act), .in_weight(in_weight), .in_psum(in_psum),
        .cs(cs), .act_out(act_out), .weight_out(weight_out), .psum_out(psum_out),
        .weight_en(weight_en), .busy(busy), .done(done)
    );

    fsa_pe_operand_sequencer #(.DATA_W(DW), .N_ACC(1), .HOLD_CYC(1), .FIFO_DEPTH(2)) dut_single (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_act(b_act), .in_weight(b_weight), .in_psum(b_psum),
        .cs(b_cs), .act_out(b_act_out), .weight_out(b_weight_out), .psum_out(b_psum_out),
        .weight_en(b_we), .busy(b_busy), .done(b_done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: queued beats plus progress through the current tile.
    beat_t      q[$];
    bit         m_alive  = 0;
    bit         m_start  = 0;
    int         m_issued = 0;
    int         m_held   = 0;
    logic [1:0] e_cs;
    bit         e_we, e_done, e_busy, e_ready, last_accept;
    beat_t      e_beat;

    int tile_we = 0, b2b_cnt = 0, pe_acc = 0, issued_total = 0;
    bit prev_done = 0, saw_full = 0;
    int pct[3] = '{20, 60, 95};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic void model_edge();
        int    pre;
        beat_t nb;
        bit    accept;
        pre    = q.size();
        accept = in_valid && m_alive && (pre < FD);
        e_cs   = 2'b11;
        e_we   = 0;
        e_done = 0;
        e_beat = '0;
        if (m_start) begin
            e_beat   = q.pop_front();
            e_cs     = 2'b00;
            e_we     = 1;
            m_issued = 1;
            m_held   = 0;
            m_start  = 0;
        end else if (m_issued > 0 && m_issued < NA) begin
            if (pre > 0) begin
                e_beat = q.pop_front();
                e_cs   = 2'b01;
                e_we   = 1;
                m_issued++;
            end else begin
                e_cs = 2'b10;
            end
        end else if (m_issued == NA && m_held < HC) begin
            e_cs = 2'b10;
            m_held++;
        end else if (m_issued == NA) begin
            e_done   = 1;
            m_issued = 0;
            m_held   = 0;
            m_start  = (pre > 0);
        end else begin
            m_start = (pre > 0);
        end
        if (accept) begin
            nb.act    = in_act;
            nb.weight = in_weight;
            nb.psum   = in_psum;
            q.push_back(nb);
        end
        last_accept = accept;
        m_alive     = 1;
        e_busy      = m_start || (m_issued > 0);
        e_ready     = (q.size() < FD);
    endfunction

    task automatic step(input bit v, input logic [DW-1:0] a, input logic [DW-1:0] w,
                        input logic [DW-1:0] p);
        in_valid  = v;
        in_act    = a;
        in_weight = w;
        in_psum   = p;
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("cs", 32'(cs), 32'(e_cs));
        check("weight_en", 32'(weight_en), 32'(e_we));
        check("act_out", 32'(act_out), 32'(e_beat.act));
        check("weight_out", 32'(weight_out), 32'(e_beat.weight));
        check("psum_out", 32'(psum_out), 32'(e_beat.psum));
        check("done", 32'(done), 32'(e_done));
        check("busy", 32'(busy), 32'(e_busy));
        check("in_ready", 32'(in_ready), 32'(e_ready));
        if (weight_en) begin
            tile_we++;
            issued_total++;
            if (cs == 2'b00) pe_acc = int'(act_out) * int'(weight_out) + int'(psum_out);
            else             pe_acc = pe_acc + int'(act_out) * int'(weight_out);
        end
        if (!in_ready) saw_full = 1;
        if (cs == 2'b00 && prev_done) b2b_cnt++;
        if (done) begin
            check("tile_pops", 32'(tile_we), 32'(NA));
            tile_we = 0;
        end
        prev_done = done;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() > 0 || m_issued > 0 || m_start) && n < 64) begin
            step(0, '0, '0, '0);
            n++;
        end
        check("drain_bound", 32'(n < 64), 32'd1);
        step(0, '0, '0, '0);
    endtask

    task automatic apply_reset();
        in_valid = 0;
        rst      = 1'b0;
        #1;
        check("rst_cs", 32'(cs), 32'd3);
        check("rst_act", 32'(act_out), 32'd0);
        check("rst_weight", 32'(weight_out), 32'd0);
        check("rst_psum", 32'(psum_out), 32'd0);
        check("rst_we", 32'(weight_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_b_ready", 32'(b_ready), 32'd0);
        q.delete();
        m_alive   = 0;
        m_start   = 0;
        m_issued  = 0;
        m_held    = 0;
        tile_we   = 0;
        prev_done = 0;
        @(posedge clk);
        @(negedge clk);
        check("rst_ready_held", 32'(in_ready), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        vec_t       tv[12];
        vec_t       bv[7];
        bit         st_v[9];
        logic [1:0] st_cs[7];
        logic [1:0] seen_cs[9];
        bit         seen_we[9];
        int         we_seen, acc_n, guard, issued_before;

        in_valid = 0; in_act = '0; in_weight = '0; in_psum = '0;
        b_valid  = 0; b_act  = '0; b_weight  = '0; b_psum  = '0;

        tv[0]  = '{1'b1, 16'd1, 16'd2, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};
        tv[1]  = '{1'b1, 16'd2, 16'd2, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1};
        tv[2]  = '{1'b1, 16'd3, 16'd2, 16'd0, 2'b00, 1'b1, 16'd1, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1};
        tv[3]  = '{1'b1, 16'd4, 16'd2, 16'd0, 2'b01, 1'b1, 16'd2, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1};
        tv[4]  = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b01, 1'b1, 16'd3, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1};
        tv[5]  = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b01, 1'b1, 16'd4, 16'd2, 16'd0, 1'b0, 1'b1, 1'b1};
        for (int i = 6; i < 10; i++)
            tv[i] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b10, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1};
        tv[10] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1};
        tv[11] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};

        bv[0] = '{1'b1, 16'd7, 16'd3, 16'd5, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};
        bv[1] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1};
        bv[2] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b00, 1'b1, 16'd7, 16'd3, 16'd5, 1'b0, 1'b1, 1'b1};
        bv[3] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b10, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1};
        bv[4] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1};
        bv[5] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};
        bv[6] = '{1'b0, 16'd0, 16'd0, 16'd0, 2'b11, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1};

        st_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        st_cs = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};

        // reset and release
        #2;
        apply_reset();
        step(0, '0, '0, '0);
        check("ready_after_release", 32'(in_ready), 32'd1);

        // streamed tile: act 1..4, weight 2
        pe_acc = 0;
        for (int i = 0; i < 12; i++) begin
            step(tv[i].v, tv[i].a, tv[i].w, tv[i].p);
            check($sformatf("tbl%0d_cs", i), 32'(cs), 32'(tv[i].cs));
            check($sformatf("tbl%0d_we", i), 32'(weight_en), 32'(tv[i].we));
            check($sformatf("tbl%0d_act", i), 32'(act_out), 32'(tv[i].ea));
            check($sformatf("tbl%0d_weight", i), 32'(weight_out), 32'(tv[i].ew));
            check($sformatf("tbl%0d_done", i), 32'(done), 32'(tv[i].done));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tv[i].busy));
            check($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(tv[i].ready));
        end
        check("pe_readout", 32'(pe_acc), 32'd20);

        // starvation: one beat, a gap, then three more
        we_seen = 0;
        for (int i = 0; i < 9; i++) begin
            step(st_v[i], DW'(10 + i), DW'(3), DW'(1));
            seen_cs[i] = cs;
            seen_we[i] = weight_en;
        end
        for (int i = 0; i < 7; i++) begin
            check($sformatf("starve%0d_cs", i), 32'(seen_cs[i+2]), 32'(st_cs[i]));
            check($sformatf("starve%0d_we", i), 32'(seen_we[i+2]), 32'(st_cs[i] != 2'b10));
            if (seen_we[i+2]) we_seen++;
        end
        check("starve_pops", 32'(we_seen), 32'd4);
        drain();

        // eight back-to-back pushes: FIFO fills, two tiles issue in order
        b2b_cnt       = 0;
        saw_full      = 0;
        issued_before = issued_total;
        acc_n         = 0;
        guard         = 0;
        while (acc_n < 8 && guard < 100) begin
            step(1, DW'(100 + acc_n), DW'(acc_n + 1), DW'(acc_n));
            if (last_accept) acc_n++;
            guard++;
        end
        check("fill_accepted", 32'(acc_n), 32'd8);
        drain();
        check("saw_full", 32'(saw_full), 32'd1);
        check("issued_8", 32'(issued_total - issued_before), 32'd8);
        check("back_to_back", 32'(b2b_cnt), 32'd1);

        // random traffic at three source densities
        for (int w = 0; w < 3; w++) begin
            for (int c = 0; c < 150; c++) begin
                step($urandom_range(99) < pct[w], DW'($urandom), DW'($urandom), DW'($urandom));
            end
        end

        // reset in the middle of a tile
        for (int c = 0; c < 9; c++) step(1, DW'($urandom), DW'($urandom), DW'($urandom));
        #2;
        apply_reset();
        step(0, '0, '0, '0);
        check("ready_after_midreset", 32'(in_ready), 32'd1);
        for (int c = 0; c < 40; c++) step($urandom_range(99) < 70, DW'($urandom), DW'($urandom), DW'($urandom));
        drain();

        // single-beat tiles with a one-cycle readout
        for (int i = 0; i < 7; i++) begin
            b_valid  = bv[i].v;
            b_act    = bv[i].a;
            b_weight = bv[i].w;
            b_psum   = bv[i].p;
            step(0, '0, '0, '0);
            check($sformatf("single%0d_cs", i), 32'(b_cs), 32'(bv[i].cs));
            check($sformatf("single%0d_we", i), 32'(b_we), 32'(bv[i].we));
            check($sformatf("single%0d_act", i), 32'(b_act_out), 32'(bv[i].ea));
            check($sformatf("single%0d_weight", i), 32'(b_weight_out), 32'(bv[i].ew));
            check($sformatf("single%0d_psum", i), 32'(b_psum_out), 32'(bv[i].ep));
            check($sformatf("single%0d_done", i), 32'(b_done), 32'(bv[i].done));
            check($sformatf("single%0d_busy", i), 32'(b_busy), 32'(bv[i].busy));
            check($sformatf("single%0d_ready", i), 32'(b_ready), 32'(bv[i].ready));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
